brnch_fetch_redirect_unit: RTL and testbench



---
 rtl/brnch_pkg.sv | 24 ++
 rtl/brnch_fetch_redirect_unit_target_calc.sv | 18 +
 rtl/brnch_fetch_redirect_unit.sv | 110 +++++++++++
 tb/tb_brnch_fetch_redirect_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/brnch_pkg.sv
// ---------------------------------------------------------------------------
// brnch_pkg: shared types for the fetch redirect unit | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package brnch_pkg;

  localparam logic [5:0] OPC_BEQ = 6'b000100;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } redir_state_t;

  typedef struct packed {
    logic        valid;
    logic        pred;
    logic [31:0] recov_pc;
  } id_br_rec_t;

endpackage

`default_nettype wire

// File: rtl/brnch_fetch_redirect_unit_target_calc.sv
// ---------------------------------------------------------------------------
// brnch_target_calc: beq target and fall-through address from the IF pc | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module brnch_target_calc (
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  output logic [31:0] target,
  output logic [31:0] fall_thru
);

  assign fall_thru = pc + 32'd4;
  assign target    = fall_thru + {{14{imm[15]}}, imm, 2'b00};

endmodule

`default_nettype wire

// File: rtl/brnch_fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// brnch_fetch_redirect_unit: IF pc steering, ID branch record, mispredict recovery.
// Optional perf counters under BRNCH_REDIRECT_PERF_EN | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module brnch_fetch_redirect_unit
  import brnch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_instr,
  input  logic        br_prediction,
  input  logic        branch_hazard_stall,
  input  logic        load_use_stall,
  input  logic        flush,
  output logic [31:0] if_pc,
  output logic        pc_write_en,
  output logic        IFID_flush,
  output logic        redirect_err,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  redir_state_t r_state;
  id_br_rec_t   r_rec;
  logic [31:0]  r_pc;
  logic [31:0]  w_target;
  logic [31:0]  w_fall_thru;
  logic         w_is_br;
  logic         w_stall;
  logic         w_vflush;
  logic         w_pred_taken;
  logic         unused_bits;

  assign w_is_br      = (if_instr[31:26] == OPC_BEQ);
  assign w_stall      = branch_hazard_stall | load_use_stall;
  // ID holds a bubble while in REDIRECT, so a flush there has nothing to recover
  assign w_vflush     = flush & r_rec.valid & (r_state != REDIRECT);
  assign w_pred_taken = w_is_br & br_prediction;
  assign unused_bits  = &{1'b0, if_instr[25:16], r_rec.pred};

  brnch_target_calc u_target_calc (
    .pc        (r_pc),
    .imm       (if_instr[15:0]),
    .target    (w_target),
    .fall_thru (w_fall_thru)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_state <= RUN;
      r_rec   <= '0;
    end else begin
      if (w_vflush) begin
        r_pc        <= r_rec.recov_pc;
        r_rec.valid <= 1'b0;
      end else if (!w_stall) begin
        r_pc           <= w_pred_taken ? w_target : w_fall_thru;
        r_rec.valid    <= w_is_br;
        r_rec.pred     <= w_pred_taken;
        r_rec.recov_pc <= w_pred_taken ? w_fall_thru : w_target;
      end

      case (r_state)
        RUN, STALL: begin
          if (w_vflush)      r_state <= REDIRECT;
          else if (w_stall)  r_state <= STALL;
          else               r_state <= RUN;
        end
        REDIRECT: r_state <= RUN;
        default:  r_state <= RUN;
      endcase
    end
  end

  assign if_pc        = r_pc;
  assign pc_write_en  = rst | w_vflush | ~w_stall;
  assign IFID_flush   = ~rst & w_vflush;
  assign redirect_err = ~rst & flush & ~r_rec.valid;

`ifdef BRNCH_REDIRECT_PERF_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_is_br && !w_vflush && !w_stall && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_vflush && (r_mispred_cnt != '1))
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;
`else
  assign branch_cnt  = '0;
  assign mispred_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_brnch_fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_brnch_fetch_redirect_unit: directed + random stimulus against a behavioural model | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_brnch_fetch_redirect_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_instr = NOP;
  logic        br_prediction = 1'b0;
  logic        branch_hazard_stall = 1'b0;
  logic        load_use_stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] if_pc;
  logic        pc_write_en;
  logic        IFID_flush;
  logic        redirect_err;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  always #5 clk = ~clk;

  brnch_fetch_redirect_unit #(.RESET_PC(RESET_PC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .if_instr            (if_instr),
    .br_prediction       (br_prediction),
    .branch_hazard_stall (branch_hazard_stall),
    .load_use_stall      (load_use_stall),
    .flush               (flush),
    .if_pc               (if_pc),
    .pc_write_en         (pc_write_en),
    .IFID_flush          (IFID_flush),
    .redirect_err        (redirect_err),
    .branch_cnt          (branch_cnt),
    .mispred_cnt         (mispred_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_pc;
  logic [31:0] m_recov = 32'd0;
  logic [31:0] m_bcnt = 32'd0;
  logic [31:0] m_mcnt = 32'd0;
  bit          m_valid = 1'b0;
  bit          m_redir = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beq(input logic [15:0] imm);
    return {6'b000100, 10'd0, imm};
  endfunction

  function automatic logic [31:0] tgt_of(input logic [31:0] pc, input logic [31:0] ins);
    return pc + 32'd4 + ({{16{ins[15]}}, ins[15:0]} << 2);
  endfunction

  // Behavioural model: what the architectural state must be after each edge
  always @(posedge clk) begin : model
    bit          br, stl, vf;
    logic [31:0] tgt;
    br  = (if_instr[31:26] == 6'b000100);
    stl = branch_hazard_stall || load_use_stall;
    vf  = flush && m_valid && !m_redir;
    tgt = tgt_of(m_pc, if_instr);
    if (rst) begin
      m_pc = RESET_PC; m_valid = 0; m_redir = 0; m_bcnt = 0; m_mcnt = 0;
    end else if (vf) begin
      m_pc = m_recov; m_valid = 0; m_redir = 1;
      if (m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
    end else begin
      m_redir = 0;
      if (!stl) begin
        if (br) begin
          if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
          m_valid = 1;
          m_recov = br_prediction ? m_pc + 32'd4 : tgt;
          m_pc    = br_prediction ? tgt : m_pc + 32'd4;
        end else begin
          m_valid = 0;
          m_pc    = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit          stl, vf;
    logic [31:0] eb, em;
    if (chk_en) begin
      stl = branch_hazard_stall || load_use_stall;
      vf  = flush && m_valid && !m_redir;
`ifdef BRNCH_REDIRECT_PERF_EN
      eb = m_bcnt; em = m_mcnt;
`else
      eb = 32'd0; em = 32'd0;
`endif
      chk("if_pc", if_pc, m_pc);
      chk("pc_write_en", {31'd0, pc_write_en}, {31'd0, rst || vf || !stl});
      chk("IFID_flush", {31'd0, IFID_flush}, {31'd0, !rst && vf});
      chk("redirect_err", {31'd0, redirect_err}, {31'd0, !rst && flush && !m_valid});
      chk("branch_cnt", branch_cnt, eb);
      chk("mispred_cnt", mispred_cnt, em);
    end
  end

  task automatic drive(input logic [31:0] ins, input logic pr, input logic bhs,
                       input logic lus, input logic fl);
    if_instr = ins; br_prediction = pr; branch_hazard_stall = bhs;
    load_use_stall = lus; flush = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_pc", if_pc, 32'h0);
    chk("reset_iff", {31'd0, IFID_flush}, 32'd0);
    rst = 1'b0; #1;
    step(); chk("pc_after_rst1", if_pc, 32'h4);
    step(); chk("pc_after_rst2", if_pc, 32'h8);

    drive(beq(16'h000D), 1, 0, 0, 0); step(); chk("jump_to_40", if_pc, 32'h40);
    drive(beq(16'h0003), 1, 0, 0, 0); step(); chk("taken_tgt", if_pc, 32'h50);
    drive(beq(16'h0010), 1, 0, 0, 1);
    chk("taken_flush_iff", {31'd0, IFID_flush}, 32'd1);
    step(); chk("taken_recov", if_pc, 32'h44);
    drive(NOP, 0, 0, 0, 1);
    chk("redirect_ignore_iff", {31'd0, IFID_flush}, 32'd0);
    step(); chk("redirect_ignore_pc", if_pc, 32'h48);

    drive(beq(16'h002D), 1, 0, 0, 0); step(); chk("jump_to_100", if_pc, 32'h100);
    drive(beq(16'hFFFE), 0, 0, 0, 0); step(); chk("nt_fallthru", if_pc, 32'h104);
    repeat (3) begin
      drive(NOP, 0, 1, 0, 0);
      chk("stall_pwe", {31'd0, pc_write_en}, 32'd0);
      step(); chk("stall_pc", if_pc, 32'h104);
    end
    drive(NOP, 0, 0, 1, 1);
    chk("stallflush_pwe", {31'd0, pc_write_en}, 32'd1);
    chk("stallflush_iff", {31'd0, IFID_flush}, 32'd1);
    step(); chk("nt_recov", if_pc, 32'hFC);
    drive(NOP, 0, 0, 0, 0); step(); chk("after_redirect", if_pc, 32'h100);
    drive(NOP, 0, 0, 0, 1);
    chk("spurious_err", {31'd0, redirect_err}, 32'd1);
    step(); chk("spurious_pc", if_pc, 32'h104);
    drive(beq(16'h0000), 0, 0, 0, 0); step(); chk("last_br_pc", if_pc, 32'h108);
`ifdef BRNCH_REDIRECT_PERF_EN
    chk("perf_branches", branch_cnt, 32'd5);
    chk("perf_mispreds", mispred_cnt, 32'd2);
`else
    chk("perf_branches_off", branch_cnt, 32'd0);
    chk("perf_mispreds_off", mispred_cnt, 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      r = $urandom();
      rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 9) < 4) ? {6'b000100, r[25:0]} : r,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) == 0);
      step();
    end
    rst = 1'b0;
    drive(NOP, 0, 0, 0, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
